// File: rtl/vc_rr_arb_ctrl_pkg.sv
// Shared definitions for the round-robin VC arbiter: state encodings,
// the FSM enum built on them, and the clog2 helper used to size grant ids.
package vc_rr_arb_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_BUSY  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      GRANT = ST_GRANT,
      BUSY  = ST_BUSY
   } arb_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/vc_rr_pick.sv
// Round-robin winner selection: lowest asserted request at or above ptr,
// falling back to the lowest asserted request overall.
module vc_rr_pick #(
   parameter int NREQS = 4,
   parameter int IDW   = 2
) (
   input  logic [NREQS-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic             pick_val,
   output logic [IDW-1:0]   pick_id
);

   logic [NREQS-1:0] masked;
   logic             m_val;
   logic [IDW-1:0]   m_id;
   logic [IDW-1:0]   u_id;

   always_comb begin
      masked = '0;
      m_val  = 1'b0;
      m_id   = '0;
      u_id   = '0;
      for (int i = 0; i < NREQS; i++) begin
         masked[i] = req[i] && (i >= int'(ptr));
      end
      // Scan high to low so the last hit written is the lowest index.
      for (int i = NREQS - 1; i >= 0; i--) begin
         if (masked[i]) begin
            m_val = 1'b1;
            m_id  = IDW'(i);
         end
         if (req[i]) u_id = IDW'(i);
      end
      pick_val = |req;
      pick_id  = m_val ? m_id : u_id;
   end

endmodule

// File: rtl/vc_rr_arb_ctrl.sv
// Round-robin arbiter controller: picks a requester, offers it to the shared
// resource, holds it until the resource reports done, then advances ptr.
module vc_rr_arb_ctrl
   import vc_rr_arb_ctrl_pkg::*;
#(
   parameter int NREQS = 4,
   parameter int IDW   = clog2(NREQS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NREQS-1:0] req_val,
   output logic [NREQS-1:0] req_rdy,
   output logic             grant_val,
   input  logic             grant_rdy,
   output logic [IDW-1:0]   grant_id,
   input  logic             done,
   output logic             busy,
   output logic [1:0]       dbg_state,
   output logic [IDW-1:0]   dbg_ptr
);

   // Handshakes: a transfer happens in a cycle where valid and ready are both
   // high. grant_val/grant_id stay stable until grant_rdy is seen; req_rdy is
   // the accept back to the winner and is only high in the transfer cycle.
   arb_state_t     state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] winner;
   logic           pick_val;
   logic [IDW-1:0] pick_id;
   logic [IDW-1:0] next_ptr;
   logic           win_req;

   vc_rr_pick #(.NREQS(NREQS), .IDW(IDW)) u_pick (
      .req      (req_val),
      .ptr      (ptr),
      .pick_val (pick_val),
      .pick_id  (pick_id)
   );

   assign win_req   = req_val[winner];
   assign next_ptr  = (winner == IDW'(NREQS - 1)) ? '0 : winner + IDW'(1);
   assign dbg_state = state;
   assign dbg_ptr   = ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr       <= '0;
         winner    <= '0;
         grant_val <= 1'b0;
         grant_id  <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_val) begin
                  state     <= GRANT;
                  winner    <= pick_id;
                  grant_val <= 1'b1;
                  grant_id  <= pick_id;
                  busy      <= 1'b1;
               end
            end
            GRANT: begin
               // A withdrawn request aborts without touching ptr.
               if (!win_req) begin
                  state     <= IDLE;
                  grant_val <= 1'b0;
                  grant_id  <= '0;
                  busy      <= 1'b0;
               end else if (grant_rdy) begin
                  state     <= BUSY;
                  grant_val <= 1'b0;
                  grant_id  <= '0;
               end
            end
            BUSY: begin
               if (done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  ptr   <= next_ptr;
               end
            end
            default: begin
               state     <= IDLE;
               grant_val <= 1'b0;
               grant_id  <= '0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      req_rdy = '0;
      if (state == GRANT && grant_rdy && win_req) req_rdy[winner] = 1'b1;
   end

endmodule

// File: tb/tb_vc_rr_arb_ctrl.sv
// Directed bench for vc_rr_arb_ctrl (NREQS=4) with an abstract reference
// model compared every falling edge plus hand-computed literal checks.
module tb_vc_rr_arb_ctrl;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic [N-1:0] req_val = '0;
   logic [N-1:0] req_rdy;
   logic         grant_val;
   logic         grant_rdy = 1'b0;
   logic [1:0]   grant_id;
   logic         done = 1'b0;
   logic         busy;
   logic [1:0]   dbg_state;
   logic [1:0]   dbg_ptr;

   int checks = 0;
   int errors = 0;

   vc_rr_arb_ctrl #(.NREQS(N), .IDW(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_val   (req_val),
      .req_rdy   (req_rdy),
      .grant_val (grant_val),
      .grant_rdy (grant_rdy),
      .grant_id  (grant_id),
      .done      (done),
      .busy      (busy),
      .dbg_state (dbg_state),
      .dbg_ptr   (dbg_ptr)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // offered: a grant is on offer; holding: the resource owns the winner.
   logic m_offered = 1'b0;
   logic m_holding = 1'b0;
   int   m_win = 0;
   int   m_ptr = 0;

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return 0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_offered <= 1'b0;
         m_holding <= 1'b0;
         m_win     <= 0;
         m_ptr     <= 0;
      end else if (m_holding) begin
         if (done) begin
            m_holding <= 1'b0;
            m_ptr     <= (m_win + 1) % N;
         end
      end else if (m_offered) begin
         if (!req_val[m_win]) begin
            m_offered <= 1'b0;
         end else if (grant_rdy) begin
            m_offered <= 1'b0;
            m_holding <= 1'b1;
         end
      end else if (req_val != '0) begin
         m_offered <= 1'b1;
         m_win     <= rr_pick(req_val, m_ptr);
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      exp_rdy = '0;
      if (m_offered && grant_rdy && req_val[m_win]) exp_rdy[m_win] = 1'b1;
      check("cmp_grant_val", 32'(grant_val), 32'(m_offered));
      check("cmp_grant_id", 32'(grant_id), m_offered ? 32'(m_win) : 32'd0);
      check("cmp_busy", 32'(busy), 32'(m_offered | m_holding));
      check("cmp_req_rdy", 32'(req_rdy), 32'(exp_rdy));
      check("cmp_ptr", 32'(dbg_ptr), 32'(m_ptr));
      check("cmp_state", 32'(dbg_state), m_holding ? 32'd2 : (m_offered ? 32'd1 : 32'd0));
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called while a grant is on offer: handshake, then done one cycle later.
   task automatic do_txn();
      grant_rdy = 1'b1;
      tick();
      grant_rdy = 1'b0;
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic wait_grant(input string name);
      int n;
      n = 0;
      while (!grant_val && n < 10) begin
         tick();
         n++;
      end
      if (!grant_val) check(name, 32'd0, 32'd1);
   endtask

   int fair_exp[5] = '{0, 1, 2, 3, 0};

   initial begin
      // Reset held with all requests high.
      #1 reset_n = 1'b0;
      req_val = 4'b1111;
      tick(); tick();
      check("rst_grant_val", 32'(grant_val), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_req_rdy", 32'(req_rdy), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      req_val = '0;
      tick(); tick();
      check("rel_busy", 32'(busy), 32'd0);

      // Single request.
      req_val = 4'b0100;
      tick();
      check("single_grant_val", 32'(grant_val), 32'd1);
      check("single_grant_id", 32'(grant_id), 32'd2);
      grant_rdy = 1'b1;
      #1;
      check("single_req_rdy", 32'(req_rdy), 32'b0100);
      tick();
      grant_rdy = 1'b0;
      req_val = '0;
      done = 1'b1;
      tick();
      done = 1'b0;
      check("single_ptr", 32'(dbg_ptr), 32'd3);

      // Wrap: ptr=3 with 0101 picks 0, then ptr=1 picks 2.
      req_val = 4'b0101;
      tick();
      check("wrap_id0", 32'(grant_id), 32'd0);
      do_txn();
      check("wrap_ptr1", 32'(dbg_ptr), 32'd1);
      tick();
      check("wrap_id2", 32'(grant_id), 32'd2);
      do_txn();
      req_val = '0;
      check("wrap_ptr3", 32'(dbg_ptr), 32'd3);

      // Abort: request 1 withdrawn while on offer, even with grant_rdy high.
      req_val = 4'b0010;
      tick();
      check("abort_id", 32'(grant_id), 32'd1);
      req_val = '0;
      grant_rdy = 1'b1;
      #1;
      check("abort_req_rdy", 32'(req_rdy), 32'd0);
      tick();
      grant_rdy = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ptr", 32'(dbg_ptr), 32'd3);
      req_val = 4'b0010;
      tick();
      check("abort_regrant_id", 32'(grant_id), 32'd1);
      do_txn();
      req_val = '0;

      // Fairness after a fresh reset, one idle cycle between grants.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      req_val = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_grant("fair_wait");
         check("fair_id", 32'(grant_id), 32'(fair_exp[i]));
         do_txn();
         check("fair_idle_gap", 32'(grant_val), 32'd0);
         tick();
         check("fair_period", 32'(grant_val), 32'd1);
      end
      // A grant to 1 is now on offer; take it into BUSY.
      check("ar_id", 32'(grant_id), 32'd1);
      grant_rdy = 1'b1;
      tick();
      grant_rdy = 1'b0;
      req_val = '0;
      check("ar_busy_before", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("ar_busy_async", 32'(busy), 32'd0);
      check("ar_state_async", 32'(dbg_state), 32'd0);
      #1 reset_n = 1'b1;
      tick();
      req_val = 4'b1000;
      tick();
      check("ar_id3", 32'(grant_id), 32'd3);
      do_txn();
      req_val = '0;
      check("ar_ptr0", 32'(dbg_ptr), 32'd0);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
